// File: rtl/aes128_iter_engine_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 engine.
package aes128_iter_engine_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUB,
    ST_MIX,
    ST_DONE
  } aes_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column byte 0 sits in the top bits, matching the state byte order.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes128_iter_engine_if.sv
// Block loader / result sink handshake bundle for the AES-128 engine.
interface aes128_iter_engine_if;
  logic [127:0] data;
  logic [127:0] key;
  logic         read_enable;
  logic         ready;
  logic [127:0] out_data;
  logic         done;
  logic         done_ack;

  modport master (output data, key, read_enable, done_ack,
                  input  ready, out_data, done);
  modport slave  (input  data, key, read_enable, done_ack,
                  output ready, out_data, done);
endinterface

// File: rtl/aes128_iter_engine_sbox.sv
// AES forward S-box: combinational byte lookup.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = SBOX[i_byte];
endmodule

// File: rtl/aes128_iter_engine.sv
// Iterative AES-128 encryptor: SBOX_LANES bytes substituted per cycle, key expanded on the fly.
// Define AES_ROUND_DEBUG_EN to expose the dbg_round / dbg_sub observation ports.
module aes128_iter_engine
  import aes128_iter_engine_pkg::*;
#(
  parameter int SBOX_LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  aes128_iter_engine_if.slave  bus
`ifdef AES_ROUND_DEBUG_EN
  ,
  output logic [3:0]           dbg_round,
  output logic [0:0]           dbg_sub
`endif
);

  localparam int LANE_CYCLES = 16 / SBOX_LANES;

  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4 &&
      SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
    $error("SBOX_LANES must be 1, 2, 4, 8 or 16");
  end

  aes_state_e   r_state, w_next_state;
  logic [127:0] r_state_reg, r_rkey, r_out_data;
  logic [3:0]   r_round, r_lane_cnt;
  logic         w_last_lane;
  logic [7:0]   w_sbox_in  [SBOX_LANES];
  logic [7:0]   w_sbox_out [SBOX_LANES];
  logic [127:0] w_sub_state, w_shifted, w_mixed, w_round_out;
  logic [31:0]  w_rot_word, w_sub_word, w_temp;
  logic [31:0]  w_k0, w_k1, w_k2, w_k3;

  assign w_last_lane = (r_lane_cnt == 4'(LANE_CYCLES - 1));

  for (genvar j = 0; j < SBOX_LANES; j++) begin : g_state_sbox
    aes_sbox u_sbox (.i_byte(w_sbox_in[j]), .o_byte(w_sbox_out[j]));
  end

  // Byte b belongs to the lane group b / SBOX_LANES and uses lane b % SBOX_LANES.
  always_comb begin
    for (int j = 0; j < SBOX_LANES; j++) w_sbox_in[j] = 8'h00;
    for (int b = 0; b < 16; b++) begin
      if (4'(b / SBOX_LANES) == r_lane_cnt) w_sbox_in[b % SBOX_LANES] = r_state_reg[127-8*b -: 8];
    end
  end

  always_comb begin
    w_sub_state = r_state_reg;
    for (int b = 0; b < 16; b++) begin
      if (4'(b / SBOX_LANES) == r_lane_cnt) w_sub_state[127-8*b -: 8] = w_sbox_out[b % SBOX_LANES];
    end
  end

  always_comb begin
    w_shifted = '0;
    w_mixed   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_shifted[127-8*(4*c+r) -: 8] = r_state_reg[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      w_mixed[127-32*c -: 32] = (r_round < 4'(NUM_ROUNDS)) ? mix_column(w_shifted[127-32*c -: 32])
                                                             : w_shifted[127-32*c -: 32];
    end
  end

  // Next round key: RotWord/SubWord of the last word, then the running XOR chain.
  assign w_rot_word = {r_rkey[23:0], r_rkey[31:24]};

  for (genvar k = 0; k < 4; k++) begin : g_key_sbox
    aes_sbox u_sbox (.i_byte(w_rot_word[31-8*k -: 8]), .o_byte(w_sub_word[31-8*k -: 8]));
  end

  assign w_temp      = w_sub_word ^ {rcon(r_round), 24'h000000};
  assign w_k0        = r_rkey[127:96] ^ w_temp;
  assign w_k1        = r_rkey[95:64] ^ w_k0;
  assign w_k2        = r_rkey[63:32] ^ w_k1;
  assign w_k3        = r_rkey[31:0] ^ w_k2;
  assign w_round_out = w_mixed ^ {w_k0, w_k1, w_k2, w_k3};

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (bus.read_enable) w_next_state = ST_SUB;
      ST_SUB:  if (w_last_lane) w_next_state = ST_MIX;
      ST_MIX:  w_next_state = (r_round == 4'(NUM_ROUNDS)) ? ST_DONE : ST_SUB;
      ST_DONE: if (bus.done_ack) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_reg <= '0;
      r_rkey      <= '0;
      r_out_data  <= '0;
      r_round     <= '0;
      r_lane_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.read_enable) begin
          r_state_reg <= bus.data ^ bus.key;
          r_rkey      <= bus.key;
          r_round     <= 4'd1;
          r_lane_cnt  <= '0;
        end
        ST_SUB: begin
          r_state_reg <= w_sub_state;
          r_lane_cnt  <= w_last_lane ? 4'd0 : r_lane_cnt + 4'd1;
        end
        ST_MIX: begin
          r_state_reg <= w_round_out;
          r_rkey      <= {w_k0, w_k1, w_k2, w_k3};
          if (r_round == 4'(NUM_ROUNDS)) r_out_data <= w_round_out;
          else                           r_round    <= r_round + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready    = (r_state == ST_IDLE);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.out_data = r_out_data;

`ifdef AES_ROUND_DEBUG_EN
  assign dbg_round = (r_state == ST_SUB || r_state == ST_MIX) ? r_round : 4'd0;
  assign dbg_sub   = (r_state == ST_SUB);
`endif

endmodule

// File: tb/tb_aes128_iter_engine.sv
// Self-checking bench for aes128_iter_engine against a from-first-principles AES-128 model.
// Honours AES_ROUND_DEBUG_EN when the design is built with it.
module tb_aes128_iter_engine;

  localparam int MAIN_LANES = 4;
  localparam int MAIN_LAT   = 1 + 10 * (16 / MAIN_LANES + 1);

  localparam logic [127:0] V1_D   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V1_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V1_OUT = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] V2_D   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V2_K   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V2_OUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checksDone   = 0;
  int   checksPassed = 0;
  logic [7:0]   sboxT [256];
  logic [3:0]   altDone;
  logic [127:0] altOut [4];

  always #5 clk = ~clk;

  aes128_iter_engine_if busIf ();

`ifdef AES_ROUND_DEBUG_EN
  logic [3:0] dbgRound;
  logic [0:0] dbgSub;
`endif

  aes128_iter_engine #(.SBOX_LANES(MAIN_LANES)) uDut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
`ifdef AES_ROUND_DEBUG_EN
    ,
    .dbg_round (dbgRound),
    .dbg_sub   (dbgSub)
`endif
  );

  // Extra engines at the other lane counts follow the main bus inputs.
  for (genvar g = 0; g < 4; g++) begin : gAlt
    localparam int LANES = (g < 2) ? (1 << g) : (1 << (g + 1));
    aes128_iter_engine_if altIf ();
    assign altIf.data        = busIf.data;
    assign altIf.key         = busIf.key;
    assign altIf.read_enable = busIf.read_enable;
    assign altIf.done_ack    = busIf.done_ack;
    assign altDone[g]        = altIf.done;
    assign altOut[g]         = altIf.out_data;
`ifdef AES_ROUND_DEBUG_EN
    logic [3:0] altDbgRound;
    logic [0:0] altDbgSub;
`endif
    aes128_iter_engine #(.SBOX_LANES(LANES)) uAlt (
      .clk (clk),
      .rst (rst),
      .bus (altIf)
`ifdef AES_ROUND_DEBUG_EN
      ,
      .dbg_round (altDbgRound),
      .dbg_sub   (altDbgSub)
`endif
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sboxT[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aesRef(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sboxT[tmp[31:24]], sboxT[tmp[23:16]], sboxT[tmp[15:8]], sboxT[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sboxT[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checksDone++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one block, optionally disturbs the bus mid-run, and waits for done.
  task automatic applyStimulus(input logic [127:0] d, input logic [127:0] k, input logic [127:0] expOut,
                               input int dropAt, input string tag);
    int n;
    n = 0;
    busIf.data = d;
    busIf.key = k;
    busIf.read_enable = 1'b1;
    do begin
      tick();
      n++;
      busIf.read_enable = 1'b0;
      if (n == dropAt) begin
        checkOutput({tag, "_busy_ready"}, 128'(busIf.ready), 128'(0));
        busIf.read_enable = 1'b1;
        busIf.data = ~d;
        busIf.key = ~k;
      end
    end while (!busIf.done && n < 400);
    busIf.read_enable = 1'b0;
    checkOutput({tag, "_latency"}, 128'(n), 128'(MAIN_LAT));
    checkOutput({tag, "_out"}, busIf.out_data, expOut);
  endtask

  task automatic ackResult(input string tag);
    busIf.done_ack = 1'b1;
    tick();
    busIf.done_ack = 1'b0;
    checkOutput({tag, "_ack_done"}, 128'(busIf.done), 128'(0));
    checkOutput({tag, "_ack_ready"}, 128'(busIf.ready), 128'(1));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, mainLat, expLat, holdCycles;
    int altLat [4];
    bit allSeen;
    logic [127:0] d, k, exp;

    busIf.data = '0;
    busIf.key = '0;
    busIf.read_enable = 1'b0;
    busIf.done_ack = 1'b0;
    buildSbox();
    repeat (3) tick();
    rst = 1'b0;

    checkOutput("reset_ready", 128'(busIf.ready), 128'(1));
    checkOutput("reset_done", 128'(busIf.done), 128'(0));
    checkOutput("reset_out", busIf.out_data, 128'(0));
`ifdef AES_ROUND_DEBUG_EN
    checkOutput("reset_dbg_round", 128'(dbgRound), 128'(0));
    checkOutput("reset_dbg_sub", 128'(dbgSub), 128'(0));
`endif

    // Vector 2 on every lane configuration at once.
    busIf.data = V2_D;
    busIf.key = V2_K;
    busIf.read_enable = 1'b1;
    n = 0;
    mainLat = 0;
    foreach (altLat[g]) altLat[g] = 0;
    do begin
      tick();
      n++;
      busIf.read_enable = 1'b0;
      if (busIf.done && mainLat == 0) mainLat = n;
      for (int g = 0; g < 4; g++) if (altDone[g] && altLat[g] == 0) altLat[g] = n;
      allSeen = (mainLat != 0);
      for (int g = 0; g < 4; g++) if (altLat[g] == 0) allSeen = 1'b0;
    end while (!allSeen && n < 400);
    checkOutput("lanes4_latency", 128'(mainLat), 128'(MAIN_LAT));
    checkOutput("lanes4_out", busIf.out_data, V2_OUT);
    for (int g = 0; g < 4; g++) begin
      expLat = 1 + 10 * (16 / ((g < 2) ? (1 << g) : (1 << (g + 1))) + 1);
      checkOutput($sformatf("alt%0d_latency", g), 128'(altLat[g]), 128'(expLat));
      checkOutput($sformatf("alt%0d_out", g), altOut[g], V2_OUT);
    end
    ackResult("lanes");

    // Busy drop with mid-run bus changes, then a long hold with read_enable noise.
    applyStimulus(V1_D, V1_K, V1_OUT, 5, "vec1_drop");
    for (int i = 0; i < 20; i++) begin
      busIf.read_enable = 1'b1;
      busIf.data = {4{$urandom()}};
      tick();
      checkOutput("hold_done", 128'(busIf.done), 128'(1));
      checkOutput("hold_out", busIf.out_data, V1_OUT);
    end
    busIf.read_enable = 1'b0;
    ackResult("hold");

    // Reset in the middle of round 5.
    busIf.data = V1_D;
    busIf.key = V1_K;
    busIf.read_enable = 1'b1;
    tick();
    busIf.read_enable = 1'b0;
    repeat (20) tick();
    checkOutput("midrun_ready", 128'(busIf.ready), 128'(0));
`ifdef AES_ROUND_DEBUG_EN
    checkOutput("midrun_dbg_round", 128'(dbgRound), 128'(5));
    checkOutput("midrun_dbg_sub", 128'(dbgSub), 128'(1));
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_done", 128'(busIf.done), 128'(0));
    checkOutput("rst_out", busIf.out_data, 128'(0));
    checkOutput("rst_ready", 128'(busIf.ready), 128'(1));
    applyStimulus(V2_D, V2_K, V2_OUT, 0, "after_rst");
    ackResult("after_rst");

    // Back-to-back: ack in the first done cycle, next block in the single idle cycle.
    applyStimulus(V1_D, V1_K, V1_OUT, 0, "b2b_first");
    ackResult("b2b_gap");
    applyStimulus(V2_D, V2_K, V2_OUT, 0, "b2b_second");
    ackResult("b2b_second");

    for (int i = 0; i < 8; i++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp = aesRef(d, k);
      applyStimulus(d, k, exp, $urandom_range(0, 40), $sformatf("rand%0d", i));
      holdCycles = $urandom_range(0, 3);
      repeat (holdCycles) begin
        tick();
        checkOutput("rand_hold_out", busIf.out_data, exp);
      end
      ackResult("rand");
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
